// File: rtl/cbus_rr_arbiter.sv
// N-to-1 burst arbiter for the cache bus: round-robin or fixed-priority grant,
// grant held for a whole burst, beat count checked against the request length.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;     // beats minus one
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [7:0] MLEN4  = 8'd3;
    localparam logic [7:0] MLEN16 = 8'd15;

endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int RR_MODE   = 1,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_PORTS],
    output cbus_resp_t       iresps [NUM_PORTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx,
    output logic             proto_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_PORTS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             perr_q, perr_d;
    logic [IDX_W-1:0] win_s;
    logic             found_s;
    int               idx_s;

    // Winner selection: scan upward from ptr+1 in round-robin mode, from 0 otherwise.
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (RR_MODE != 0) begin
                idx_s = (int'(ptr_q) + 1 + k) % NUM_PORTS;
            end else begin
                idx_s = k;
            end
            if (!found_s && ireqs[idx_s].valid) begin
                found_s = 1'b1;
                win_s   = IDX_W'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for grant, rr pointer, beat counter and error pulse.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        perr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = BUSY;
                    grant_d = win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (oresp.ready && oresp.last) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                    cnt_d   = 8'd0;
                    perr_d  = (cnt_q != ireqs[grant_q].len);
                end else if (oresp.ready) begin
                    // Counter saturates; an over-long burst flags every extra beat.
                    if (cnt_q == 8'hFF) begin
                        perr_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RESET;
            cnt_q   <= 8'd0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    // Data path: forward the granted request down and the response up; all-zero otherwise.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            iresps[i] = '0;
        end
        if (state_q == BUSY) begin
            oreq = ireqs[grant_q];
            if (!reset) begin
                iresps[grant_q] = oresp;
            end else begin
                iresps[grant_q] = '0;
            end
        end else begin
            oreq = '0;
        end
    end

    assign busy      = (state_q == BUSY);
    assign grant_idx = grant_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench: a 4-port round-robin instance and a 4-port fixed-priority instance
// driven with hand-computed vectors.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    logic clk;
    logic reset;

    cbus_req_t  rr_req   [4];
    cbus_resp_t rr_iresp [4];
    cbus_req_t  rr_oreq;
    cbus_resp_t rr_oresp;
    logic       rr_busy;
    logic [1:0] rr_gidx;
    logic       rr_perr;

    cbus_req_t  fp_req   [4];
    cbus_resp_t fp_iresp [4];
    cbus_req_t  fp_oreq;
    cbus_resp_t fp_oresp;
    logic       fp_busy;
    logic [1:0] fp_gidx;
    logic       fp_perr;

    int n_checks = 0;
    int n_pass   = 0;

    cbus_rr_arbiter #(.NUM_PORTS(4), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .ireqs(rr_req), .iresps(rr_iresp),
        .oreq(rr_oreq), .oresp(rr_oresp), .busy(rr_busy),
        .grant_idx(rr_gidx), .proto_err(rr_perr)
    );

    cbus_rr_arbiter #(.NUM_PORTS(4), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset), .ireqs(fp_req), .iresps(fp_iresp),
        .oreq(fp_oreq), .oresp(fp_oresp), .busy(fp_busy),
        .grant_idx(fp_gidx), .proto_err(fp_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [7:0] len, input logic wr);
        rr_req[p].valid    = 1'b1;
        rr_req[p].is_write = wr;
        rr_req[p].size     = 3'd3;
        rr_req[p].addr     = 32'h0000_1000 * 32'(p + 1);
        rr_req[p].strobe   = 8'hFF;
        rr_req[p].data     = 64'hA5A5_0000 + 64'(p);
        rr_req[p].len      = len;
        rr_req[p].burst    = 2'b01;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_busy", 64'(rr_busy), 64'd0);
        check_eq("rst_gidx", 64'(rr_gidx), 64'd0);
        check_eq("rst_perr", 64'(rr_perr), 64'd0);
        check_eq("rst_oreq_valid", 64'(rr_oreq.valid), 64'd0);
        check_eq("rst_fp_busy", 64'(fp_busy), 64'd0);
        reset = 1'b0;
    endtask

    // From IDLE: one edge to grant, then nbeats beats with last on the final one.
    task automatic do_burst(input int p, input int nbeats, input logic exp_perr);
        logic [63:0] pat;
        tick();
        check_eq("grant_busy", 64'(rr_busy), 64'd1);
        check_eq("grant_idx", 64'(rr_gidx), 64'(p));
        check_eq("oreq_valid", 64'(rr_oreq.valid), 64'd1);
        check_eq("oreq_addr", 64'(rr_oreq.addr), 64'h0000_1000 * 64'(p + 1));
        check_eq("oreq_len", 64'(rr_oreq.len), 64'(rr_req[p].len));
        check_eq("oreq_wr", 64'(rr_oreq.is_write), 64'(rr_req[p].is_write));
        for (int b = 0; b < nbeats; b++) begin
            pat = 64'hD000_0000 + 64'(p * 256 + b);
            rr_oresp.ready = 1'b1;
            rr_oresp.last  = (b == nbeats - 1);
            rr_oresp.data  = pat;
            #1;
            check_eq("up_data", rr_iresp[p].data, pat);
            check_eq("up_ready", 64'(rr_iresp[p].ready), 64'd1);
            check_eq("up_last", 64'(rr_iresp[p].last), 64'(b == nbeats - 1));
            for (int q = 0; q < 4; q++) begin
                if (q != p) begin
                    check_eq("other_ready", 64'(rr_iresp[q].ready), 64'd0);
                end
            end
            tick();
            if (b != nbeats - 1) begin
                check_eq("mid_busy", 64'(rr_busy), 64'd1);
                check_eq("mid_perr", 64'(rr_perr), 64'd0);
            end
        end
        rr_oresp = '0;
        check_eq("end_busy", 64'(rr_busy), 64'd0);
        check_eq("end_perr", 64'(rr_perr), 64'(exp_perr));
    endtask

    initial begin
        reset    = 1'b1;
        rr_oresp = '0;
        fp_oresp = '0;
        for (int i = 0; i < 4; i++) begin
            rr_req[i] = '0;
            fp_req[i] = '0;
        end
        apply_reset();

        // Port 0 read, 16 beats, len matches.
        set_req(0, MLEN16, 1'b0);
        #1;
        check_eq("idle_oreq_valid", 64'(rr_oreq.valid), 64'd0);
        do_burst(0, 16, 1'b0);
        rr_req[0] = '0;
        tick();
        check_eq("t1_perr_after", 64'(rr_perr), 64'd0);

        // All four ports valid, single-beat bursts: 0,1,2,3,0.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, MLEN1, 1'b0);
        end
        do_burst(0, 1, 1'b0);
        do_burst(1, 1, 1'b0);
        do_burst(2, 1, 1'b0);
        do_burst(3, 1, 1'b0);
        do_burst(0, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rr_req[i] = '0;
        end
        tick();

        // Fixed priority: ports 1 and 3 valid, port 1 always wins.
        fp_req[1].valid = 1'b1;
        fp_req[1].len   = MLEN1;
        fp_req[3].valid = 1'b1;
        fp_req[3].len   = MLEN1;
        for (int r = 0; r < 3; r++) begin
            tick();
            check_eq("fp_busy", 64'(fp_busy), 64'd1);
            check_eq("fp_gidx", 64'(fp_gidx), 64'd1);
            fp_oresp.ready = 1'b1;
            fp_oresp.last  = 1'b1;
            fp_oresp.data  = 64'(r);
            #1;
            check_eq("fp_p1_ready", 64'(fp_iresp[1].ready), 64'd1);
            check_eq("fp_p3_ready", 64'(fp_iresp[3].ready), 64'd0);
            tick();
            fp_oresp = '0;
            check_eq("fp_end_busy", 64'(fp_busy), 64'd0);
        end
        fp_req[1] = '0;
        fp_req[3] = '0;

        // Port 2 write, len=4 but last after 2 beats: one error pulse.
        set_req(2, MLEN4, 1'b1);
        do_burst(2, 2, 1'b1);
        rr_req[2] = '0;
        tick();
        check_eq("t4_perr_drop", 64'(rr_perr), 64'd0);
        check_eq("t4_idle", 64'(rr_busy), 64'd0);

        // Reset on beat 5 of a 16-beat burst.
        set_req(0, MLEN16, 1'b0);
        tick();
        check_eq("t5_busy", 64'(rr_busy), 64'd1);
        for (int b = 0; b < 4; b++) begin
            rr_oresp.ready = 1'b1;
            rr_oresp.last  = 1'b0;
            tick();
        end
        reset = 1'b1;
        #1;
        check_eq("t5_no_fwd", 64'(rr_iresp[0].ready), 64'd0);
        tick();
        check_eq("t5_rst_busy", 64'(rr_busy), 64'd0);
        check_eq("t5_rst_oreq", 64'(rr_oreq.valid), 64'd0);
        for (int q = 0; q < 4; q++) begin
            check_eq("t5_rst_iresp", 64'(rr_iresp[q].ready), 64'd0);
        end
        reset    = 1'b0;
        rr_oresp = '0;

        // Port 0 granted first after reset; port 1 waits through its burst.
        set_req(0, MLEN4, 1'b0);
        set_req(1, MLEN1, 1'b0);
        do_burst(0, 4, 1'b0);
        rr_req[0] = '0;
        do_burst(1, 1, 1'b0);
        rr_req[1] = '0;
        tick();
        check_eq("final_idle", 64'(rr_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Parametrised N-to-1 arbiter for the simplified burst cache bus (cbus_req_t / cbus_resp_t).
- Sits between NUM_PORTS cache masters (icache, dcache, uncached bypass, PTW, …) and the single cbus-to-AXI converter.
- Generalises the fixed two-port cbus mux:
  - arbitrary port count;
  - selectable round-robin or fixed priority;
  - grant held across a whole burst;
  - beat counting checked against len, with a protocol-error pulse.

Parameters:
NUM_PORTS, 2, number of upstream masters; legal range 1..16.
RR_MODE, 1, 1 = round-robin, 0 = fixed priority with lowest index highest.
IDX_W, $clog2(NUM_PORTS) (min 1), derived; not to be overridden.

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
ireqs  in  NUM_PORTS x cbus_req_t  upstream requests
iresps  out  NUM_PORTS x cbus_resp_t  upstream responses
oreq  out  cbus_req_t  downstream request
oresp  in  cbus_resp_t  downstream response
busy  out  1  arbiter holds a grant
grant_idx  out  IDX_W  currently granted port, valid when busy=1
proto_err  out  1  one-cycle pulse on beat/len mismatch

Behaviour:
Reset and reset values:
- Reset values: state=IDLE, busy=0, grant_idx=0, proto_err=0, beat counter=0, rr pointer=NUM_PORTS-1 (port 0 wins first).
- oreq is all-zero in IDLE. Every iresps[i] is all-zero except the granted port in BUSY.
- Reset asserted mid-burst: go to IDLE next edge, no response forwarded that cycle, counter cleared. Downstream cleanup is the converter's own reset.

States:
- IDLE:
  - If any ireqs[i].valid, pick a winner and register grant_idx; move to BUSY next cycle.
  - RR_MODE=1: first valid index scanning (ptr+1) mod NUM_PORTS upward, wrapping.
  - RR_MODE=0: lowest valid index.
  - No valid request: stay in IDLE.
- BUSY:
  - oreq = ireqs[grant_idx] unmodified (valid, is_write, size, addr, strobe, data, len, burst).
  - iresps[grant_idx] = oresp.
  - Beat counter increments on each oresp.ready.
  - On oresp.ready && oresp.last: return to IDLE next cycle; RR pointer := grant_idx; counter := 0.

Latency:
- Request valid at edge N in IDLE gives oreq.valid at cycle N+1.
- One dead IDLE cycle follows every burst, so back-to-back bursts are ≥1 cycle apart.
- Combinational paths: only oresp→iresps and ireqs[grant]→oreq, no logic on them.

Length check:
- On the last beat, if counter != oreq.len (counter counts beats before this one, 0-based), pulse proto_err for one cycle (registered, one cycle after the last beat).
- If counter reaches 255 with ready && !last, pulse proto_err and saturate.
- The grant is still released only on last.

Protocol rules:
- Requester must hold valid and all fields stable from grant until last.
- If the granted valid drops while BUSY, the arbiter stays BUSY (no abort) and keeps forwarding.
- Non-granted ports see ready=0 and must keep waiting.
- Simultaneous: a new request arriving on the last-beat cycle is ignored until IDLE. A request from the port just served is eligible but loses to any other valid port in RR mode.
- NUM_PORTS=1: degenerates to a registered-grant passthrough; grant_idx is constant 0.

Test Plan:
1. Reset, then port 0 issues a read with len=MLEN16 and 16 ready beats, last on beat 16 → oreq.valid first at cycle+1, iresps[0] mirrors all 16 beats, busy falls after last, proto_err stays 0.
2. NUM_PORTS=4, RR_MODE=1, ports 0–3 all valid continuously with len=MLEN1 → grants in order 0,1,2,3,0 with one IDLE cycle between grants.
3. RR_MODE=0, ports 1 and 3 always valid → port 1 wins every arbitration and port 3 is never granted.
4. Port 2 issues a write with len=MLEN4, downstream asserts last on beat 2 → grant released, proto_err pulses once on the following cycle.
5. Reset asserted on beat 5 of a 16-beat burst → next cycle busy=0, oreq.valid=0, all iresps zero; after reset, port 0 is granted first.
6. Port 1 valid while port 0 is mid-burst → iresps[1].ready=0 throughout; port 1 is granted on the cycle after port 0's last beat plus one IDLE cycle.
